// File: rtl/flag_register_unit.sv
// flag_register_unit
//   Producer side of the branch-condition interface. Captures carry and sign/zero
//   status from ALU results into architectural flag registers. It also tracks
//   multi-cycle ALU ops so that fetch can stall a dependent branch.
//
// Parameters
//   WIDTH          ALU result width; sign is taken from bit WIDTH-1
//
// Ports
//   clk            system clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   op_issue       pulse: flag-writing ALU op issued this cycle
//   op_upd_carry   issued op writes carry (sampled with op_issue)
//   op_upd_sign    issued op writes sign/zero (sampled with op_issue)
//   alu_valid      ALU result/carry valid this cycle
//   alu_result     ALU result
//   alu_carry      ALU carry-out
//   carry          registered carry flag
//   sign           registered sign code: 01 zero, 10 negative, 00 positive
//   flags_pending  multi-cycle op outstanding, flags stale
//   proto_err      sticky handshake-violation flag
module flag_register_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_issue,
  input  logic             op_upd_carry,
  input  logic             op_upd_sign,
  input  logic             alu_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             carry,
  output logic [1:0]       sign,
  output logic             flags_pending,
  output logic             proto_err
);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e     state_q;
  logic       carry_q;
  logic [1:0] sign_q;
  logic       perr_q;
  logic       pu_c_q;   // outstanding op writes carry
  logic       pu_s_q;   // outstanding op writes sign
  logic [1:0] sign_enc;

  // Zero takes priority over negative; 2'b11 is never produced.
  always_comb begin
    sign_enc = 2'b00;
    if (alu_result == '0) begin
      sign_enc = 2'b01;
    end else if (alu_result[WIDTH-1]) begin
      sign_enc = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      carry_q <= 1'b0;
      sign_q  <= 2'b01;
      perr_q  <= 1'b0;
      pu_c_q  <= 1'b0;
      pu_s_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (op_issue && alu_valid) begin
            // Single-cycle op: result arrives with the issue.
            if (op_upd_carry) carry_q <= alu_carry;
            if (op_upd_sign)  sign_q  <= sign_enc;
          end else if (op_issue) begin
            pu_c_q  <= op_upd_carry;
            pu_s_q  <= op_upd_sign;
            state_q <= StPending;
          end else if (alu_valid) begin
            // Result with no op outstanding.
            perr_q <= 1'b1;
          end
        end
        StPending: begin
          if (alu_valid) begin
            if (pu_c_q) carry_q <= alu_carry;
            if (pu_s_q) sign_q  <= sign_enc;
            if (op_issue) begin
              // Back-to-back: the new op becomes the outstanding one.
              pu_c_q <= op_upd_carry;
              pu_s_q <= op_upd_sign;
            end else begin
              state_q <= StIdle;
            end
          end else if (op_issue) begin
            // Second op before the first completed: dropped.
            perr_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign carry         = carry_q;
  assign sign          = sign_q;
  assign flags_pending = (state_q == StPending);
  assign proto_err     = perr_q;

endmodule

// File: tb/tb_flag_register_unit.sv
module tb_flag_register_unit;

  logic        clk;
  logic        rst_n;
  logic        op_issue;
  logic        op_upd_carry;
  logic        op_upd_sign;
  logic        alu_valid;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        carry;
  logic [1:0]  sign;
  logic        flags_pending;
  logic        proto_err;

  int checks;
  int failures;

  flag_register_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_issue     (op_issue),
    .op_upd_carry (op_upd_carry),
    .op_upd_sign  (op_upd_sign),
    .alu_valid    (alu_valid),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .carry        (carry),
    .sign         (sign),
    .flags_pending(flags_pending),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all four outputs at once.
  task automatic chk_all(input string tag, input logic c, input logic [1:0] s,
                         input logic p, input logic e);
    chk({tag, ".carry"}, {31'd0, carry}, {31'd0, c});
    chk({tag, ".sign"}, {30'd0, sign}, {30'd0, s});
    chk({tag, ".pending"}, {31'd0, flags_pending}, {31'd0, p});
    chk({tag, ".perr"}, {31'd0, proto_err}, {31'd0, e});
  endtask

  // Apply one cycle of stimulus, sample 1 time unit after the edge, then go quiet.
  task automatic drive(input logic iss, input logic uc, input logic us, input logic v,
                       input logic [31:0] res, input logic c);
    op_issue     = iss;
    op_upd_carry = uc;
    op_upd_sign  = us;
    alu_valid    = v;
    alu_result   = res;
    alu_carry    = c;
    @(posedge clk);
    #1;
    op_issue     = 1'b0;
    op_upd_carry = 1'b0;
    op_upd_sign  = 1'b0;
    alu_valid    = 1'b0;
    alu_result   = 32'd0;
    alu_carry    = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b1;
    op_issue     = 1'b0;
    op_upd_carry = 1'b0;
    op_upd_sign  = 1'b0;
    alu_valid    = 1'b0;
    alu_result   = 32'd0;
    alu_carry    = 1'b0;

    // Reset values, during and after reset.
    #2 rst_n = 1'b0;
    #10;
    chk_all("in_reset", 1'b0, 2'b01, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset", 1'b0, 2'b01, 1'b0, 1'b0);

    // Single-cycle op, negative result with carry.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1);
    chk_all("single_neg", 1'b1, 2'b10, 1'b0, 1'b0);

    // Carry-only op: sign untouched.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'd5, 1'b0);
    chk_all("carry_only", 1'b0, 2'b10, 1'b0, 1'b0);

    // Op with no update bits: flags untouched.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1);
    chk_all("no_upd", 1'b0, 2'b10, 1'b0, 1'b0);

    // Multi-cycle sign-only op: pending for 4 cycles, then zero, carry kept.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("mc_pend0", {31'd0, flags_pending}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("mc_pend%0d", i + 1), {31'd0, flags_pending}, 32'd1);
      chk($sformatf("mc_sign_hold%0d", i + 1), {30'd0, sign}, 32'd2);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1);
    chk_all("mc_done", 1'b0, 2'b01, 1'b0, 1'b0);

    // Pending op (writes both) completes while a sign-only op issues.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    chk_all("b2b_issue", 1'b0, 2'b01, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 1'b1);
    chk_all("b2b_overlap", 1'b1, 2'b00, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk_all("b2b_second", 1'b1, 2'b10, 1'b0, 1'b0);

    // Spurious alu_valid in IDLE: flags unchanged, sticky error.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    chk_all("spurious", 1'b1, 2'b10, 1'b0, 1'b1);
    idle();
    idle();
    chk_all("spurious_sticky", 1'b1, 2'b10, 1'b0, 1'b1);

    // Reset clears the sticky error.
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst_clear", 1'b0, 2'b01, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Overlap violation: second issue ignored (its carry update dropped).
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk_all("ovl_issue", 1'b0, 2'b01, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk_all("ovl_viol", 1'b0, 2'b01, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 1'b1);
    chk_all("ovl_done", 1'b0, 2'b10, 1'b0, 1'b1);

    // Reset asserted mid-PENDING, off the clock edge.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
    chk_all("pre_rst_carry", 1'b1, 2'b10, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    chk_all("pre_rst_pend", 1'b1, 2'b10, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("mid_pend_rst", 1'b0, 2'b01, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("after_mid_rst", 1'b0, 2'b01, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
